// File: rtl/ex_unit_m.sv
// ============================================================================
// Module   : ex_unit_m
// Brief    : RV32IM execute stage. Forwarding, operand select, ALU, and a
//            multi-cycle multiply/divide engine feeding the EX/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_unit_m #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_idex,
    input  logic [4:0]      alu_op_idex,
    input  logic            op1_sel_idex,
    input  logic            op2_sel_idex,
    input  logic [XLEN-1:0] pc_idex,
    input  logic [XLEN-1:0] imm_idex,
    input  logic [XLEN-1:0] data_1_idex,
    input  logic [XLEN-1:0] data_2_idex,
    input  logic [RA_W-1:0] rs1_addr_idex,
    input  logic [RA_W-1:0] rs2_addr_idex,
    input  logic [RA_W-1:0] reg_write_addr_idex,
    input  logic            reg_write_en_idex,
    input  logic [XLEN-1:0] alu_res_mem,
    input  logic [RA_W-1:0] reg_write_addr_mem,
    input  logic            reg_write_en_mem,
    input  logic [XLEN-1:0] write_data_wb,
    input  logic [RA_W-1:0] reg_write_addr_wb,
    input  logic            reg_write_en_wb,
    output logic [XLEN-1:0] result_exmem,
    output logic [XLEN-1:0] store_data_exmem,
    output logic [RA_W-1:0] reg_write_addr_exmem,
    output logic            reg_write_en_exmem,
    output logic            valid_exmem,
    output logic            ex_busy
);

    localparam int C_SH_W    = $clog2(XLEN);
    localparam int C_CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic [XLEN-1:0] w_fwd_1, w_fwd_2, w_op1, w_op2, w_alu, w_addend, w_sum;
    logic [C_SH_W-1:0] w_shamt;
    logic            w_is_mop, w_issue;

    // Latched M-op context
    logic [XLEN-1:0] r_op_a, r_op_b, r_quo, r_rem, r_dvs;
    logic [2:0]      r_f3;
    logic [RA_W-1:0] r_rd;
    logic            r_we, r_a_neg, r_b_neg;

    // Forwarding: MEM beats WB, x0 is never forwarded
    always_comb begin
        w_fwd_1 = data_1_idex;
        if (reg_write_en_mem && reg_write_addr_mem != '0 && reg_write_addr_mem == rs1_addr_idex)
            w_fwd_1 = alu_res_mem;
        else if (reg_write_en_wb && reg_write_addr_wb != '0 && reg_write_addr_wb == rs1_addr_idex)
            w_fwd_1 = write_data_wb;
        w_fwd_2 = data_2_idex;
        if (reg_write_en_mem && reg_write_addr_mem != '0 && reg_write_addr_mem == rs2_addr_idex)
            w_fwd_2 = alu_res_mem;
        else if (reg_write_en_wb && reg_write_addr_wb != '0 && reg_write_addr_wb == rs2_addr_idex)
            w_fwd_2 = write_data_wb;
    end

    assign w_op1    = op1_sel_idex ? pc_idex  : w_fwd_1;
    assign w_op2    = op2_sel_idex ? imm_idex : w_fwd_2;
    assign w_shamt  = w_op2[C_SH_W-1:0];
    assign w_addend = alu_op_idex[4] ? ~w_op2 : w_op2;
    assign w_sum    = w_op1 + w_addend + {{(XLEN-1){1'b0}}, alu_op_idex[4]};

    always_comb begin
        w_alu = '0;
        case (alu_op_idex)
            5'b00000, 5'b10000: w_alu = w_sum;
            5'b00001: w_alu = w_op1 << w_shamt;
            5'b00010: w_alu = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            5'b00011: w_alu = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            5'b00100: w_alu = w_op1 ^ w_op2;
            5'b00101: w_alu = w_op1 >> w_shamt;
            5'b10101: w_alu = $signed(w_op1) >>> w_shamt;
            5'b00110: w_alu = w_op1 | w_op2;
            5'b00111: w_alu = w_op1 & w_op2;
            5'b11000: w_alu = w_op2;
            default:  w_alu = '0;
        endcase
    end

    assign w_is_mop = (alu_op_idex[4:3] == 2'b01);
    assign w_issue  = (r_state == S_IDLE) && valid_idex && w_is_mop && !flush;
    assign ex_busy  = w_issue || (r_state == S_MUL) || (r_state == S_DIV);

    // Divider operands are converted to magnitudes at issue; funct3[0]=0 means signed
    logic            w_div_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    assign w_div_sgn = !alu_op_idex[0];
    assign w_a_neg   = w_div_sgn && w_fwd_1[XLEN-1];
    assign w_b_neg   = w_div_sgn && w_fwd_2[XLEN-1];
    assign w_a_mag   = w_a_neg ? -w_fwd_1 : w_fwd_1;
    assign w_b_mag   = w_b_neg ? -w_fwd_2 : w_fwd_2;

    // Restoring divide step: one quotient bit per cycle
    logic [XLEN:0] w_trial;
    assign w_trial = {r_rem, r_quo[XLEN-1]} - {1'b0, r_dvs};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: if (w_issue) begin
                w_state_nxt = alu_op_idex[2] ? S_DIV : S_MUL;
                w_cnt_nxt   = alu_op_idex[2] ? C_CNT_W'(XLEN) : C_CNT_W'(MUL_LAT);
            end
            S_MUL, S_DIV: begin
                w_cnt_nxt = r_cnt - C_CNT_W'(1);
                if (r_cnt == C_CNT_W'(1))
                    w_state_nxt = S_DONE;
            end
            S_DONE: if (!stall) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_f3    <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
            r_a_neg <= 1'b0;
            r_b_neg <= 1'b0;
        end else if (w_issue) begin
            r_op_a  <= w_fwd_1;
            r_op_b  <= w_fwd_2;
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_dvs   <= w_b_mag;
            r_f3    <= alu_op_idex[2:0];
            r_rd    <= reg_write_addr_idex;
            r_we    <= reg_write_en_idex;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
        end else if (r_state == S_DIV) begin
            r_rem <= w_trial[XLEN] ? {r_rem[XLEN-2:0], r_quo[XLEN-1]} : w_trial[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
        end
    end

    // Product is formed from the latched operands; MUL_LAT only paces the result
    logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
    logic              w_a_sx, w_b_sx;
    assign w_a_sx  = (r_f3[1:0] == 2'b01 || r_f3[1:0] == 2'b10) && r_op_a[XLEN-1];
    assign w_b_sx  = (r_f3[1:0] == 2'b01) && r_op_b[XLEN-1];
    assign w_mul_a = {{XLEN{w_a_sx}}, r_op_a};
    assign w_mul_b = {{XLEN{w_b_sx}}, r_op_b};
    assign w_prod  = w_mul_a * w_mul_b;

    logic            w_div_zero, w_div_ovf;
    logic [XLEN-1:0] w_quo_res, w_rem_res, w_m_res;
    assign w_div_zero = (r_op_b == '0);
    assign w_div_ovf  = !r_f3[0] && (r_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_op_b == '1);

    always_comb begin
        w_quo_res = (r_a_neg ^ r_b_neg) ? -r_quo : r_quo;
        w_rem_res = r_a_neg ? -r_rem : r_rem;
        if (w_div_zero) begin
            w_quo_res = '1;
            w_rem_res = r_op_a;
        end else if (w_div_ovf) begin
            w_quo_res = r_op_a;
            w_rem_res = '0;
        end
        if (r_f3[2])
            w_m_res = r_f3[1] ? w_rem_res : w_quo_res;
        else
            w_m_res = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_exmem         <= '0;
            store_data_exmem     <= '0;
            reg_write_addr_exmem <= '0;
            reg_write_en_exmem   <= 1'b0;
            valid_exmem          <= 1'b0;
        end else if (!stall) begin
            if (!flush && r_state == S_DONE) begin
                result_exmem         <= w_m_res;
                store_data_exmem     <= r_op_b;
                reg_write_addr_exmem <= r_rd;
                reg_write_en_exmem   <= r_we;
                valid_exmem          <= 1'b1;
            end else if (!flush && r_state == S_IDLE && !(valid_idex && w_is_mop)) begin
                result_exmem         <= w_alu;
                store_data_exmem     <= w_fwd_2;
                reg_write_addr_exmem <= reg_write_addr_idex;
                reg_write_en_exmem   <= reg_write_en_idex && valid_idex;
                valid_exmem          <= valid_idex;
            end else begin
                result_exmem         <= '0;
                store_data_exmem     <= '0;
                reg_write_addr_exmem <= '0;
                reg_write_en_exmem   <= 1'b0;
                valid_exmem          <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_unit_m.sv
// ============================================================================
// Module   : tb_ex_unit_m
// Brief    : Directed scoreboard bench for ex_unit_m.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_unit_m;
    localparam int XLEN = 32, RA_W = 5, MUL_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, stall, flush, valid_idex, op1_sel_idex, op2_sel_idex, reg_write_en_idex;
    logic [4:0] alu_op_idex;
    logic [XLEN-1:0] pc_idex, imm_idex, data_1_idex, data_2_idex, alu_res_mem, write_data_wb;
    logic [RA_W-1:0] rs1_addr_idex, rs2_addr_idex, reg_write_addr_idex, reg_write_addr_mem, reg_write_addr_wb;
    logic reg_write_en_mem, reg_write_en_wb;
    logic [XLEN-1:0] result_exmem, store_data_exmem;
    logic [RA_W-1:0] reg_write_addr_exmem;
    logic reg_write_en_exmem, valid_exmem, ex_busy;

    ex_unit_m #(.XLEN(XLEN), .RA_W(RA_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_idex(valid_idex),
        .alu_op_idex(alu_op_idex), .op1_sel_idex(op1_sel_idex), .op2_sel_idex(op2_sel_idex),
        .pc_idex(pc_idex), .imm_idex(imm_idex), .data_1_idex(data_1_idex), .data_2_idex(data_2_idex),
        .rs1_addr_idex(rs1_addr_idex), .rs2_addr_idex(rs2_addr_idex),
        .reg_write_addr_idex(reg_write_addr_idex), .reg_write_en_idex(reg_write_en_idex),
        .alu_res_mem(alu_res_mem), .reg_write_addr_mem(reg_write_addr_mem), .reg_write_en_mem(reg_write_en_mem),
        .write_data_wb(write_data_wb), .reg_write_addr_wb(reg_write_addr_wb), .reg_write_en_wb(reg_write_en_wb),
        .result_exmem(result_exmem), .store_data_exmem(store_data_exmem),
        .reg_write_addr_exmem(reg_write_addr_exmem), .reg_write_en_exmem(reg_write_en_exmem),
        .valid_exmem(valid_exmem), .ex_busy(ex_busy)
    );

    int checks = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub, up;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = {32'h0, a}; ub = {32'h0, b};
        ia = $signed(a); ib = $signed(b);
        case (op)
            5'b00000: return a + b;
            5'b10000: return a - b;
            5'b00001: return a << b[4:0];
            5'b00010: return (ia < ib) ? 32'd1 : 32'd0;
            5'b00011: return (a < b) ? 32'd1 : 32'd0;
            5'b00100: return a ^ b;
            5'b00101: return a >> b[4:0];
            5'b10101: return 32'($signed(a) >>> b[4:0]);
            5'b00110: return a | b;
            5'b00111: return a & b;
            5'b11000: return b;
            5'b01000: begin p = 64'(sa * sb); return p[31:0]; end
            5'b01001: begin p = 64'(sa * sb); return p[63:32]; end
            5'b01010: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            5'b01011: begin up = ua * ub; p = up; return p[63:32]; end
            5'b01100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            5'b01101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'b01110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            5'b01111: return (b == 0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, wait for it to land in EX/MEM, score it
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_val, input int exp_busy);
        int busy;
        bit got;
        logic [31:0] e;
        exp_q.push_back(exp_val);
        alu_op_idex = op; data_1_idex = a; data_2_idex = b;
        reg_write_addr_idex = 5'd9; reg_write_en_idex = 1'b1; valid_idex = 1'b1;
        #1;
        busy = 0; got = 0;
        for (int i = 0; i < 100; i++) begin
            if (ex_busy) busy++;
            @(posedge clk); #1;
            if (valid_exmem) begin got = 1; break; end
        end
        valid_idex = 1'b0;
        check({tag, "_landed"}, 64'(got), 64'd1);
        e = exp_q.pop_front();
        check(tag, 64'(result_exmem), 64'(e));
        check({tag, "_rd"}, 64'(reg_write_addr_exmem), 64'd9);
        check({tag, "_busy"}, 64'(busy), 64'(exp_busy));
    endtask

    task automatic run_ref(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int eb;
        eb = (op[4:3] == 2'b01) ? (op[2] ? XLEN + 1 : MUL_LAT + 1) : 0;
        run_op(tag, op, a, b, ref_alu(op, a, b), eb);
    endtask

    initial begin
        int busy, writes;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; valid_idex = 1'b0;
        alu_op_idex = '0; op1_sel_idex = 1'b0; op2_sel_idex = 1'b0;
        pc_idex = '0; imm_idex = '0; data_1_idex = '0; data_2_idex = '0;
        rs1_addr_idex = 5'd1; rs2_addr_idex = 5'd2; reg_write_addr_idex = '0; reg_write_en_idex = 1'b0;
        alu_res_mem = '0; reg_write_addr_mem = '0; reg_write_en_mem = 1'b0;
        write_data_wb = '0; reg_write_addr_wb = '0; reg_write_en_wb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", 64'(result_exmem), 64'd0);
        check("rst_valid", 64'(valid_exmem), 64'd0);
        check("rst_we", 64'(reg_write_en_exmem), 64'd0);
        check("rst_busy", 64'(ex_busy), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ALU operations
        run_ref("add", 5'b00000, 32'd5, 32'd6);
        run_ref("sub", 5'b10000, 32'd3, 32'd10);
        run_ref("sll", 5'b00001, 32'd1, 32'd35);
        run_ref("slt", 5'b00010, 32'hFFFF_FFFF, 32'd1);
        run_ref("sltu", 5'b00011, 32'hFFFF_FFFF, 32'd1);
        run_ref("xor", 5'b00100, 32'hF0F0_1234, 32'h0FF0_4321);
        run_ref("srl", 5'b00101, 32'h8000_0000, 32'd4);
        run_ref("sra", 5'b10101, 32'h8000_0000, 32'd4);
        run_ref("or", 5'b00110, 32'hA000_0005, 32'h0500_0050);
        run_ref("and", 5'b00111, 32'hFF00_FF00, 32'h0FF0_0FF0);
        op2_sel_idex = 1'b1; imm_idex = 32'h1234_5000;
        run_op("lui", 5'b11000, 32'd77, 32'd88, 32'h1234_5000, 0);
        op1_sel_idex = 1'b1; pc_idex = 32'h0000_1000; imm_idex = 32'h20;
        run_op("auipc", 5'b00000, 32'd77, 32'd88, 32'h0000_1020, 0);
        op1_sel_idex = 1'b0; op2_sel_idex = 1'b0;

        // Forwarding
        rs1_addr_idex = 5'd5; rs2_addr_idex = 5'd6;
        reg_write_en_mem = 1'b1; reg_write_addr_mem = 5'd5; alu_res_mem = 32'd100;
        reg_write_en_wb = 1'b1; reg_write_addr_wb = 5'd6; write_data_wb = 32'd3;
        run_op("fwd_mem_wb", 5'b00000, 32'd11, 32'd22, 32'd103, 0);
        check("fwd_store_wb", 64'(store_data_exmem), 64'd3);
        reg_write_addr_wb = 5'd5; write_data_wb = 32'd7;
        run_op("fwd_mem_beats_wb", 5'b00000, 32'd11, 32'd22, 32'd122, 0);
        check("fwd_store_reg", 64'(store_data_exmem), 64'd22);
        rs1_addr_idex = 5'd0; rs2_addr_idex = 5'd0;
        reg_write_addr_mem = 5'd0; reg_write_addr_wb = 5'd0;
        run_op("fwd_x0", 5'b00000, 32'd4, 32'd5, 32'd9, 0);
        rs1_addr_idex = 5'd1; rs2_addr_idex = 5'd2;
        reg_write_en_mem = 1'b0; reg_write_en_wb = 1'b0;

        // Multiply / divide
        run_ref("mul", 5'b01000, 32'h8000_0000, 32'd2);
        run_ref("mulh", 5'b01001, 32'hFFFF_FFFD, 32'd5);
        run_ref("mulhu", 5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_ref("mulhsu", 5'b01010, 32'hFFFF_FFFF, 32'd2);
        run_ref("div", 5'b01100, 32'hFFFF_FFF9, 32'd2);
        run_ref("rem", 5'b01110, 32'hFFFF_FFF9, 32'd2);
        run_ref("divu_zero", 5'b01101, 32'd7, 32'd0);
        run_ref("rem_ovf", 5'b01110, 32'h8000_0000, 32'hFFFF_FFFF);
        run_ref("div_ovf", 5'b01100, 32'h8000_0000, 32'hFFFF_FFFF);
        run_ref("div_neg_divisor", 5'b01100, 32'd7, 32'hFFFF_FFFE);
        run_ref("remu_zero", 5'b01111, 32'd7, 32'd0);
        run_ref("remu", 5'b01111, 32'd100, 32'd7);

        // STALL held across DONE
        exp_q.push_back(32'd14);
        alu_op_idex = 5'b01101; data_1_idex = 32'd100; data_2_idex = 32'd7; valid_idex = 1'b1;
        #1;
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            if (!ex_busy) break;
            busy++;
            @(posedge clk); #1;
        end
        check("stall_busy", 64'(busy), 64'(XLEN + 1));
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_hold_valid", 64'(valid_exmem), 64'd0);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        valid_idex = 1'b0;
        check("stall_land_valid", 64'(valid_exmem), 64'd1);
        check("stall_land_result", 64'(result_exmem), 64'(exp_q.pop_front()));

        // FLUSH while dividing (cnt=20)
        alu_op_idex = 5'b01100; data_1_idex = 32'hFFFF_FF9C; data_2_idex = 32'd7; valid_idex = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        flush = 1'b1; valid_idex = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(ex_busy), 64'd0);
        check("flush_valid", 64'(valid_exmem), 64'd0);
        writes = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_exmem) writes++;
        end
        check("flush_no_write", 64'(writes), 64'd0);

        // Reset in the middle of a divide, outputs frozen by STALL beforehand
        run_ref("pre_rst_add", 5'b00000, 32'd5, 32'd6);
        stall = 1'b1;
        alu_op_idex = 5'b01101; data_1_idex = 32'd1000; data_2_idex = 32'd3; valid_idex = 1'b1;
        repeat (23) @(posedge clk);
        #1;
        check("rst_mid_busy_pre", 64'(ex_busy), 64'd1);
        check("rst_mid_hold", 64'(result_exmem), 64'd11);
        rst_n = 1'b0; valid_idex = 1'b0; stall = 1'b0;
        #1;
        check("rst_mid_result", 64'(result_exmem), 64'd0);
        check("rst_mid_rd", 64'(reg_write_addr_exmem), 64'd0);
        check("rst_mid_we", 64'(reg_write_en_exmem), 64'd0);
        check("rst_mid_valid", 64'(valid_exmem), 64'd0);
        check("rst_mid_busy", 64'(ex_busy), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_ref("divu_after_rst", 5'b01101, 32'd1000, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
